booth_operand_feeder: RTL and testbench

//  Upstream sequencer for the 8-bit Booth multiplier. Buffers signed operand pairs in a small FIFO.

---
 rtl/booth_feed_pkg.sv | 17 +
 rtl/booth_feed_fifo.sv | 56 +++++
 rtl/booth_operand_feeder.sv | 149 ++++++++++++++
 tb/tb_booth_operand_feeder.sv | 332 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/booth_feed_pkg.sv
// Shared definitions for the Booth multiplier operand feeder:
// FSM state encoding and default configuration values.
package booth_feed_pkg;

    localparam int unsigned DEF_WIDTH          = 8;
    localparam int unsigned DEF_DEPTH          = 4;
    localparam int unsigned DEF_TIMEOUT_CYCLES = 64;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        ISSUE = 3'd1,
        GUARD = 3'd2,
        WAIT  = 3'd3,
        HOLD  = 3'd4
    } state_t;

endpackage

// File: rtl/booth_feed_fifo.sv
// Operand-pair FIFO for the Booth feeder. Each entry holds {a, b} (2*WIDTH bits).
// Pointers carry one extra wrap bit so full and empty are distinguishable.
// A push is ignored while full even if a pop happens in the same cycle.
module booth_feed_fifo
    import booth_feed_pkg::*;
#(
    parameter int unsigned WIDTH = DEF_WIDTH,
    parameter int unsigned DEPTH = DEF_DEPTH
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               push,
    input  logic [2*WIDTH-1:0] din,
    input  logic               pop,
    output logic [2*WIDTH-1:0] head,
    output logic               full,
    output logic               empty
);

    localparam int unsigned PW = $clog2(DEPTH);

    logic [2*WIDTH-1:0] mem [DEPTH];
    logic [PW:0]        wptr;
    logic [PW:0]        rptr;
    logic               do_push;
    logic               do_pop;

    assign full    = (wptr[PW] != rptr[PW]) && (wptr[PW-1:0] == rptr[PW-1:0]);
    assign empty   = (wptr == rptr);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign head    = mem[rptr[PW-1:0]];

    // Storage array; contents need no reset since empty gates every read.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wptr[PW-1:0]] <= din;
        end
    end

    // Read and write pointers, wrapping modulo 2*DEPTH.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wptr <= '0;
            rptr <= '0;
        end else begin
            if (do_push) begin
                wptr <= wptr + 1'b1;
            end
            if (do_pop) begin
                rptr <= rptr + 1'b1;
            end
        end
    end

endmodule

// File: rtl/booth_operand_feeder.sv
// Upstream sequencer for the Booth multiplier: queues signed operand pairs,
// issues one multiplication at a time, captures the product and offers it
// on a valid/ready result port.
// Optional watchdog: define BOOTH_FEED_TIMEOUT_EN to bound the wait for
// mul_finish to TIMEOUT_CYCLES; otherwise res_err is constant 0.
module booth_operand_feeder
    import booth_feed_pkg::*;
#(
    parameter int unsigned WIDTH          = DEF_WIDTH,
    parameter int unsigned DEPTH          = DEF_DEPTH,
    parameter int unsigned TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [WIDTH-1:0]   in_a,
    input  logic [WIDTH-1:0]   in_b,
    output logic               mul_start,
    output logic [WIDTH-1:0]   mul_multiplicand,
    output logic [WIDTH-1:0]   mul_multiplier,
    input  logic               mul_finish,
    input  logic [2*WIDTH-1:0] mul_product,
    output logic               res_valid,
    input  logic               res_ready,
    output logic [2*WIDTH-1:0] res_product,
    output logic               res_err,
    output logic               busy
);

    if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0 || TIMEOUT_CYCLES < 1) begin : g_bad_cfg
        $error("booth_operand_feeder: DEPTH must be a power of 2 >= 2 and TIMEOUT_CYCLES >= 1");
    end

    state_t             state;
    logic [2*WIDTH-1:0] head;
    logic               full;
    logic               empty;
    logic               push;
    logic               pop;

    assign in_ready = !full;
    assign push     = in_valid && in_ready;

    // Pop exactly when the FSM moves into ISSUE, so the head lands in the operand regs.
    always_comb begin
        pop = 1'b0;
        if (!empty) begin
            if (state == IDLE) begin
                pop = 1'b1;
            end else if (state == HOLD && res_ready) begin
                pop = 1'b1;
            end
        end
    end

    booth_feed_fifo #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (push),
        .din   ({in_a, in_b}),
        .pop   (pop),
        .head  (head),
        .full  (full),
        .empty (empty)
    );

`ifdef BOOTH_FEED_TIMEOUT_EN
    localparam int unsigned WDW = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [WDW-1:0] WDOG_LAST = WDW'(TIMEOUT_CYCLES - 1);
    logic [WDW-1:0] wdog;
`else
    assign res_err = 1'b0;
`endif

    // Sequencer FSM with registered start, operand, result and status outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state            <= IDLE;
            mul_start        <= 1'b0;
            mul_multiplicand <= '0;
            mul_multiplier   <= '0;
            res_valid        <= 1'b0;
            res_product      <= '0;
            busy             <= 1'b0;
`ifdef BOOTH_FEED_TIMEOUT_EN
            res_err          <= 1'b0;
            wdog             <= '0;
`endif
        end else begin
            mul_start <= 1'b0;
            case (state)
                IDLE: begin
                end
                ISSUE: begin
                    state <= GUARD;
                end
                // A finish still high from the previous operation is ignored here.
                GUARD: begin
                    state <= WAIT;
                end
                WAIT: begin
                    if (mul_finish) begin
                        res_product <= mul_product;
                        res_valid   <= 1'b1;
                        state       <= HOLD;
`ifdef BOOTH_FEED_TIMEOUT_EN
                    end else if (wdog == WDOG_LAST) begin
                        res_product <= '0;
                        res_err     <= 1'b1;
                        res_valid   <= 1'b1;
                        state       <= HOLD;
                    end else begin
                        wdog <= wdog + 1'b1;
`endif
                    end
                end
                HOLD: begin
                    if (res_ready) begin
                        res_valid <= 1'b0;
`ifdef BOOTH_FEED_TIMEOUT_EN
                        res_err   <= 1'b0;
`endif
                        state     <= IDLE;
                        busy      <= 1'b0;
                    end
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
            endcase
            // Issue path shared by IDLE and HOLD; overrides the assignments above.
            if (pop) begin
                state                              <= ISSUE;
                mul_start                          <= 1'b1;
                {mul_multiplicand, mul_multiplier} <= head;
                busy                               <= 1'b1;
`ifdef BOOTH_FEED_TIMEOUT_EN
                wdog                               <= '0;
`endif
            end
        end
    end

endmodule

// File: tb/tb_booth_operand_feeder.sv
// Self-checking bench for booth_operand_feeder with a behavioural Booth
// multiplier downstream. The multiplier keeps finish high until the cycle
// after the next start, so a stale finish is present during GUARD.
`timescale 1ns/1ps
module tb_booth_operand_feeder;

    localparam int LAT = 6;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [7:0]  in_a;
    logic [7:0]  in_b;
    logic        mul_start;
    logic [7:0]  mul_multiplicand;
    logic [7:0]  mul_multiplier;
    logic        mul_finish = 1'b0;
    logic [15:0] mul_product = '0;
    logic        res_valid;
    logic        res_ready;
    logic [15:0] res_product;
    logic        res_err;
    logic        busy;

    int nchk = 0;
    int nerr = 0;
    int starts = 0;
    int opnd_bad = 0;
    bit hang = 1'b0;

    logic [15:0] rq[$];
    logic        eq[$];

    always #5 clk = ~clk;

    booth_operand_feeder #(
        .WIDTH          (8),
        .DEPTH          (4),
        .TIMEOUT_CYCLES (64)
    ) dut (
        .clk              (clk),
        .rst_n            (rst_n),
        .in_valid         (in_valid),
        .in_ready         (in_ready),
        .in_a             (in_a),
        .in_b             (in_b),
        .mul_start        (mul_start),
        .mul_multiplicand (mul_multiplicand),
        .mul_multiplier   (mul_multiplier),
        .mul_finish       (mul_finish),
        .mul_product      (mul_product),
        .res_valid        (res_valid),
        .res_ready        (res_ready),
        .res_product      (res_product),
        .res_err          (res_err),
        .busy             (busy)
    );

    // Behavioural multiplier (not reset, like the real one).
    logic signed [7:0] ma = '0;
    logic signed [7:0] mb = '0;
    int                mcnt = 0;
    bit                mclr = 1'b0;

    always @(posedge clk) begin
        if (mul_start) begin
            ma   <= mul_multiplicand;
            mb   <= mul_multiplier;
            mcnt <= LAT;
            mclr <= 1'b1;
        end else begin
            if (mclr) begin
                mul_finish <= 1'b0;
                mclr       <= 1'b0;
            end
            if (mcnt != 0) begin
                mcnt <= mcnt - 1;
                if (mcnt == 1 && !hang) begin
                    mul_product <= ma * mb;
                    mul_finish  <= 1'b1;
                end
            end
        end
    end

    // Monitors: start pulses, operand stability, accepted results.
    always @(posedge clk) begin
        if (mul_start) starts++;
        if (rst_n && busy && !mul_start && mcnt != 0 &&
            (mul_multiplicand != ma || mul_multiplier != mb)) opnd_bad++;
        if (rst_n && res_valid && res_ready) begin
            rq.push_back(res_product);
            eq.push_back(res_err);
        end
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        nchk++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    function automatic logic [15:0] rq_at(input int i);
        if (i < rq.size()) return rq[i];
        return 'x;
    endfunction

    function automatic logic eq_at(input int i);
        if (i < eq.size()) return eq[i];
        return 1'bx;
    endfunction

    // Called at a negedge; returns at the negedge after the accepting edge, in_valid still 1.
    task automatic push_pair(input logic [7:0] a, input logic [7:0] b, output bit ok);
        in_a = a;
        in_b = b;
        in_valid = 1'b1;
        ok = 1'b0;
        for (int i = 0; i < 200; i++) begin
            if (in_ready) begin
                ok = 1'b1;
                @(posedge clk);
                break;
            end
            @(negedge clk);
        end
        @(negedge clk);
    endtask

    task automatic wait_res(input int n);
        int t = 0;
        while (rq.size() < n && t < 300) begin
            @(negedge clk);
            t++;
        end
        chk("result_arrived", 32'(rq.size() >= n), 32'd1);
    endtask

    typedef struct {
        logic [7:0]  a;
        logic [7:0]  b;
        logic [15:0] p;
    } vec_t;

    vec_t vt[8];
    vec_t pv[6];

    initial begin
        bit ok;
        int s0;
        int acc;
        bit take;

        vt[0] = '{8'd7,    8'd5,    16'h0023};
        vt[1] = '{8'd9,    8'd9,    16'h0051};
        vt[2] = '{8'hFA,   8'd3,    16'hFFEE};
        vt[3] = '{8'd2,    8'd3,    16'h0006};
        vt[4] = '{8'h80,   8'h80,   16'h4000};
        vt[5] = '{8'h7F,   8'h80,   16'hC080};
        vt[6] = '{8'd0,    8'hFF,   16'h0000};
        vt[7] = '{8'hFF,   8'hFF,   16'h0001};

        pv[0] = '{8'd1,    8'd2,    16'h0002};
        pv[1] = '{8'd3,    8'hFC,   16'hFFF4};
        pv[2] = '{8'hFB,   8'hFA,   16'h001E};
        pv[3] = '{8'd7,    8'd8,    16'h0038};
        pv[4] = '{8'd10,   8'hF6,   16'hFF9C};
        pv[5] = '{8'hF4,   8'd11,   16'hFF7C};

        rst_n = 1'b0;
        in_valid = 1'b0;
        in_a = '0;
        in_b = '0;
        res_ready = 1'b1;
        repeat (3) @(negedge clk);
        chk("rst_in_ready",  32'(in_ready),  32'd1);
        chk("rst_mul_start", 32'(mul_start), 32'd0);
        chk("rst_res_valid", 32'(res_valid), 32'd0);
        chk("rst_res_err",   32'(res_err),   32'd0);
        chk("rst_busy",      32'(busy),      32'd0);
        chk("rst_product",   32'(res_product), 32'd0);
        chk("rst_operands",  32'({mul_multiplicand, mul_multiplier}), 32'd0);
        rst_n = 1'b1;
        @(negedge clk);

        // Single operations from idle: latency, product, error flag, one start each.
        for (int i = 0; i < 8; i++) begin
            s0 = starts;
            rq.delete();
            eq.delete();
            push_pair(vt[i].a, vt[i].b, ok);
            in_valid = 1'b0;
            chk("vec_accept", 32'(ok), 32'd1);
            chk("vec_idle_cycle", 32'(mul_start), 32'd0);
            @(negedge clk);
            chk("vec_issue_cycle", 32'(mul_start), 32'd1);
            wait_res(1);
            chk("vec_product", 32'(rq_at(0)), 32'(vt[i].p));
            chk("vec_err", 32'(eq_at(0)), 32'd0);
            chk("vec_starts", 32'(starts - s0), 32'd1);
        end

        // Back-to-back pushes produce results in order.
        s0 = starts;
        rq.delete();
        eq.delete();
        push_pair(8'd9, 8'd9, ok);
        push_pair(8'hFA, 8'd3, ok);
        in_valid = 1'b0;
        wait_res(2);
        chk("b2b_first",  32'(rq_at(0)), 32'h0051);
        chk("b2b_second", 32'(rq_at(1)), 32'hFFEE);
        chk("b2b_starts", 32'(starts - s0), 32'd2);

        // Stalled consumer fills the FIFO; then drain with a full-FIFO pop.
        s0 = starts;
        rq.delete();
        eq.delete();
        res_ready = 1'b0;
        acc = 0;
        for (int c = 0; c < 30; c++) begin
            in_valid = (acc < 6);
            if (acc < 6) begin
                in_a = pv[acc].a;
                in_b = pv[acc].b;
            end
            take = in_valid && in_ready;
            @(posedge clk);
            if (take) acc++;
            @(negedge clk);
        end
        chk("stall_accepted",  32'(acc), 32'd5);
        chk("stall_in_ready",  32'(in_ready), 32'd0);
        chk("stall_res_valid", 32'(res_valid), 32'd1);
        chk("stall_busy",      32'(busy), 32'd1);
        chk("stall_starts",    32'(starts - s0), 32'd1);
        chk("stall_held_prod", 32'(res_product), 32'(pv[0].p));
        res_ready = 1'b1;
        take = in_valid && in_ready;
        chk("fullpop_in_ready", 32'(in_ready), 32'd0);
        @(posedge clk);
        if (take) acc++;
        @(negedge clk);
        chk("fullpop_after_ready", 32'(in_ready), 32'd1);
        chk("fullpop_restart", 32'(mul_start), 32'd1);
        for (int c = 0; c < 200 && (acc < 6 || rq.size() < 6); c++) begin
            in_valid = (acc < 6);
            if (acc < 6) begin
                in_a = pv[acc].a;
                in_b = pv[acc].b;
            end
            take = in_valid && in_ready;
            @(posedge clk);
            if (take) acc++;
            @(negedge clk);
        end
        in_valid = 1'b0;
        chk("drain_count", 32'(rq.size()), 32'd6);
        for (int i = 0; i < 6; i++) begin
            chk("drain_product", 32'(rq_at(i)), 32'(pv[i].p));
        end
        chk("drain_starts", 32'(starts - s0), 32'd6);
        repeat (3) @(negedge clk);

        // Reset in the middle of WAIT with a second pair queued.
        rq.delete();
        eq.delete();
        push_pair(8'd3, 8'd4, ok);
        push_pair(8'd4, 8'd4, ok);
        in_valid = 1'b0;
        repeat (3) @(negedge clk);
        chk("mid_wait_busy",  32'(busy), 32'd1);
        chk("mid_wait_valid", 32'(res_valid), 32'd0);
        rst_n = 1'b0;
        @(negedge clk);
        chk("abort_busy",     32'(busy), 32'd0);
        chk("abort_in_ready", 32'(in_ready), 32'd1);
        chk("abort_start",    32'(mul_start), 32'd0);
        chk("abort_operands", 32'({mul_multiplicand, mul_multiplier}), 32'd0);
        rst_n = 1'b1;
        s0 = starts;
        repeat (10) @(negedge clk);
        chk("abort_fifo_empty", 32'(busy), 32'd0);
        chk("abort_no_start",   32'(starts - s0), 32'd0);
        chk("abort_no_result",  32'(rq.size()), 32'd0);
        push_pair(8'd2, 8'd3, ok);
        in_valid = 1'b0;
        wait_res(1);
        chk("post_reset_prod", 32'(rq_at(0)), 32'h0006);
        chk("post_reset_err",  32'(eq_at(0)), 32'd0);

`ifdef BOOTH_FEED_TIMEOUT_EN
        // Multiplier never finishes: watchdog ends WAIT after 64 cycles.
        rq.delete();
        eq.delete();
        hang = 1'b1;
        push_pair(8'd1, 8'd1, ok);
        in_valid = 1'b0;
        @(negedge clk);
        chk("to_issue", 32'(mul_start), 32'd1);
        repeat (65) @(negedge clk);
        chk("to_not_yet", 32'(res_valid), 32'd0);
        @(negedge clk);
        chk("to_valid",   32'(res_valid), 32'd1);
        chk("to_err",     32'(res_err), 32'd1);
        chk("to_product", 32'(res_product), 32'd0);
        hang = 1'b0;
        repeat (2) @(negedge clk);
        rq.delete();
        eq.delete();
        push_pair(8'd2, 8'd2, ok);
        in_valid = 1'b0;
        wait_res(1);
        chk("to_recover_prod", 32'(rq_at(0)), 32'h0004);
        chk("to_recover_err",  32'(eq_at(0)), 32'd0);
`endif

        chk("operand_stability", 32'(opnd_bad), 32'd0);
        $display("Result: errors=%0d of %0d checks", nerr, nchk);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout: got stuck expected finish");
        $fatal(1, "timeout");
    end

endmodule
